// File: rtl/peak_frame_tx.sv
// peak_frame_tx: snapshots the per-window peak after a settle delay and streams it
// as a 9-byte checksummed frame over a byte valid/ready link, counting dropped windows.
module peak_frame_tx #(
    parameter int         CAPTURE_DLY = 3,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        win_pulse,
    input  logic [47:0] peak_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  seq_num,
    output logic [15:0] overrun_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  idx;
    logic [47:0] snap;
    logic [7:0]  fseq;
    logic [7:0]  chk;
    logic [7:0]  next_byte;
    logic [71:0] frame;
    logic        last;
    logic        accept;
    assign chk = fseq ^ snap[47:40] ^ snap[39:32] ^ snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
    assign frame = {SYNC_BYTE, fseq, snap, chk};
    // byte idx+1 of the frame, loaded into tx_data on each handshake
    assign next_byte = 8'(frame >> {4'd7 - idx, 3'b000});
    assign last = state == SEND && tx_valid && tx_ready && idx == 4'd8;
    assign accept = win_pulse && (state == IDLE || last);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            snap        <= '0;
            fseq        <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            seq_num     <= '0;
            overrun_cnt <= '0;
        end else begin
            if (win_pulse)
                seq_num <= seq_num + 8'd1;
            // a window arriving while a frame is still out is dropped; only its count survives
            if (win_pulse && !accept && overrun_cnt != 16'hFFFF)
                overrun_cnt <= overrun_cnt + 16'd1;
            if (accept) begin
                state <= WAIT;
                cnt   <= 4'(CAPTURE_DLY - 1);
                fseq  <= seq_num + 8'd1;
                busy  <= 1'b1;
            end
            case (state)
                WAIT: begin
                    if (cnt == 4'd0) begin
                        snap     <= peak_in;
                        idx      <= '0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (idx == 4'd8) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            if (!win_pulse) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= next_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_peak_frame_tx.sv
// tb_peak_frame_tx: three instances (capture delay 3, 1, 15) on shared stimulus, each checked
// every cycle against a frame-level reference model, plus directed frame tables and corner cases.
module tb_peak_frame_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        win_pulse;
    logic        tx_ready;
    logic [47:0] peak_in;
    logic [7:0]  tx_data [3];
    logic        tx_valid [3];
    logic        busy [3];
    logic [7:0]  seq_num [3];
    logic [15:0] overrun_cnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        peak_frame_tx #(.CAPTURE_DLY(g == 0 ? 3 : g == 1 ? 1 : 15), .SYNC_BYTE(8'hA5)) u_dut (
            .clk(clk), .rst(rst), .win_pulse(win_pulse), .peak_in(peak_in),
            .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready),
            .busy(busy[g]), .seq_num(seq_num[g]), .overrun_cnt(overrun_cnt[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rmode = 0;
    logic [7:0] got[$];

    // reference model: one window at a time, sampled DLY cycles after acceptance
    int         m_dly [3] = '{3, 1, 15};
    logic       m_busy [3];
    logic       m_valid [3];
    logic [7:0] m_seq [3];
    logic [7:0] m_fseq [3];
    int         m_ovr [3];
    int         m_wait [3];
    int         m_sent [3];
    logic [7:0] m_frame [3][9];

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    function automatic logic [7:0] fchk(input logic [7:0] s, input logic [47:0] p);
        logic [7:0] x = s;
        for (int i = 0; i < 6; i++) x ^= p[8*i +: 8];
        return x;
    endfunction

    task automatic model(input int k);
        bit lst;
        bit acc;
        if (rst) begin
            m_busy[k] = 0; m_valid[k] = 0; m_seq[k] = 0; m_fseq[k] = 0;
            m_ovr[k] = 0; m_wait[k] = 0; m_sent[k] = 0;
            return;
        end
        lst = m_valid[k] && tx_ready && m_sent[k] == 8;
        acc = win_pulse && (!m_busy[k] || lst);
        if (win_pulse) m_seq[k] = m_seq[k] + 8'd1;
        if (win_pulse && !acc && m_ovr[k] < 65535) m_ovr[k]++;
        if (m_valid[k]) begin
            if (tx_ready) begin
                m_sent[k]++;
                if (m_sent[k] == 9) begin
                    m_valid[k] = 0;
                    m_busy[k] = 0;
                end
            end
        end else if (m_busy[k]) begin
            m_wait[k]--;
            if (m_wait[k] == 0) begin
                m_frame[k][0] = 8'hA5;
                m_frame[k][1] = m_fseq[k];
                for (int i = 0; i < 6; i++) m_frame[k][2+i] = peak_in[47-8*i -: 8];
                m_frame[k][8] = fchk(m_fseq[k], peak_in);
                m_valid[k] = 1;
                m_sent[k] = 0;
            end
        end
        if (acc) begin
            m_busy[k] = 1;
            m_wait[k] = m_dly[k];
            m_fseq[k] = m_seq[k];
        end
    endtask

    task automatic step();
        if (!rst && tx_valid[0] === 1'b1 && tx_ready) got.push_back(tx_data[0]);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("tx_valid", k, 64'(tx_valid[k]), 64'(m_valid[k]));
            check("busy", k, 64'(busy[k]), 64'(m_busy[k]));
            check("seq_num", k, 64'(seq_num[k]), 64'(m_seq[k]));
            check("overrun_cnt", k, 64'(overrun_cnt[k]), 64'(m_ovr[k]));
            if (m_valid[k]) check("tx_data", k, 64'(tx_data[k]), 64'(m_frame[k][m_sent[k]]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        win_pulse = 1'b0;
        tx_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [47:0] p);
        peak_in = p;
        win_pulse = 1'b1;
        step();
        win_pulse = 1'b0;
    endtask

    task automatic run_until_frame(input int max);
        for (int i = 0; i < max && got.size() < 9; i++) begin
            tx_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !tx_ready : 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic check_frame(input logic [7:0] s, input logic [47:0] p, input logic [7:0] ck);
        logic [7:0] e [9];
        e[0] = 8'hA5;
        e[1] = s;
        for (int i = 0; i < 6; i++) e[2+i] = p[47-8*i -: 8];
        e[8] = ck;
        check("frame_len", 0, 64'(got.size()), 64'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) check($sformatf("byte%0d", i), 0, 64'(got[i]), 64'(e[i]));
    endtask

    typedef struct {
        logic [47:0] peak;
        logic [7:0]  seq;
        logic [7:0]  chk;
    } vec_t;
    vec_t tbl [6];

    initial begin
        logic [47:0] p1;
        logic [47:0] p2;
        int n;
        rst = 1'b1; win_pulse = 1'b0; tx_ready = 1'b0; peak_in = '0;
        tbl[0] = '{48'h0123_4567_89AB, 8'h01, 8'h23};
        tbl[1] = '{48'h0000_0000_0000, 8'h02, 8'h02};
        tbl[2] = '{48'hFFFF_FFFF_FFFF, 8'h03, 8'h03};
        tbl[3] = '{48'h0000_0000_00FF, 8'h04, 8'hFB};
        tbl[4] = '{48'hA5A5_A5A5_A5A5, 8'h05, 8'h05};
        tbl[5] = '{48'h1122_3344_5566, 8'h06, 8'h71};

        do_reset();
        check("rst_tx_valid", 0, 64'(tx_valid[0]), 64'd0);
        check("rst_tx_data", 0, 64'(tx_data[0]), 64'd0);
        check("rst_busy", 0, 64'(busy[0]), 64'd0);
        check("rst_seq", 0, 64'(seq_num[0]), 64'd0);
        check("rst_ovr", 0, 64'(overrun_cnt[0]), 64'd0);

        // directed frames with hand-computed checksums, tx_ready held high
        rmode = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            got.delete();
            pulse(tbl[i].peak);
            for (n = 0; n < 40 && busy[0]; n++) step();
            check("latency", 0, 64'(n), 64'd12);
            check_frame(tbl[i].seq, tbl[i].peak, tbl[i].chk);
            check("tbl_ovr", 0, 64'(overrun_cnt[0]), 64'd0);
        end

        // backpressure: alternating then random tx_ready
        for (int r = 1; r <= 2; r++) begin
            do_reset();
            rmode = r;
            got.delete();
            p1 = 48'({$urandom(), $urandom()});
            pulse(p1);
            run_until_frame(200);
            check_frame(8'h01, p1, fchk(8'h01, p1));
            for (int i = 0; i < 40 && busy[0]; i++) step();
        end

        // overrun while the sink is stalled
        do_reset();
        rmode = 0;
        got.delete();
        p1 = 48'hDEAD_BEEF_0042;
        pulse(p1);
        repeat (3) step();
        repeat (16) begin
            peak_in = 48'({$urandom(), $urandom()});
            step();
        end
        pulse(48'h1111_2222_3333);
        check("ovr_cnt", 0, 64'(overrun_cnt[0]), 64'd1);
        check("ovr_seq", 0, 64'(seq_num[0]), 64'd2);
        run_until_frame(40);
        check_frame(8'h01, p1, fchk(8'h01, p1));
        for (int i = 0; i < 40 && busy[0]; i++) step();

        // window on the exact cycle the last byte is accepted
        do_reset();
        tx_ready = 1'b1;
        got.delete();
        p1 = 48'h0A0B_0C0D_0E0F;
        p2 = 48'h5566_7788_99AA;
        pulse(p1);
        for (int i = 0; i < 40 && !(got.size() == 8 && tx_valid[0]); i++) step();
        check("pre_last", 0, 64'(got.size()), 64'd8);
        pulse(p2);
        check("back2back_busy", 0, 64'(busy[0]), 64'd1);
        check("back2back_ovr", 0, 64'(overrun_cnt[0]), 64'd0);
        got.delete();
        run_until_frame(40);
        check_frame(8'h02, p2, fchk(8'h02, p2));
        for (int i = 0; i < 40 && busy[0]; i++) step();

        // reset in the middle of a frame
        do_reset();
        tx_ready = 1'b1;
        got.delete();
        pulse(48'hCAFE_F00D_1234);
        for (int i = 0; i < 40 && got.size() < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", 0, 64'(tx_valid[0]), 64'd0);
        check("midrst_busy", 0, 64'(busy[0]), 64'd0);
        check("midrst_seq", 0, 64'(seq_num[0]), 64'd0);
        got.delete();
        p2 = 48'h0102_0304_0506;
        pulse(p2);
        run_until_frame(40);
        check_frame(8'h01, p2, fchk(8'h01, p2));
        for (int i = 0; i < 40 && busy[0]; i++) step();

        // sampling instant: peak_in ramps by one each cycle after the window strobe
        do_reset();
        tx_ready = 1'b1;
        got.delete();
        p1 = 48'h0000_0000_1000;
        pulse(p1);
        for (int i = 0; i < 40 && got.size() < 9; i++) begin
            peak_in = peak_in + 48'd1;
            step();
        end
        check_frame(8'h01, p1 + 48'd3, fchk(8'h01, p1 + 48'd3));
        for (int i = 0; i < 40 && busy[2]; i++) step();

        // sequence wrap after 256 windows
        do_reset();
        tx_ready = 1'b1;
        repeat (256) pulse(48'({$urandom(), $urandom()}));
        for (int k = 0; k < 3; k++) check("seq_wrap", k, 64'(seq_num[k]), 64'd0);

        // randomized traffic against the model
        do_reset();
        repeat (3000) begin
            win_pulse = $urandom_range(0, 19) == 0;
            tx_ready = $urandom_range(0, 9) < 7;
            peak_in = 48'({$urandom(), $urandom()});
            step();
        end

        // overrun counter saturation
        do_reset();
        tx_ready = 1'b0;
        win_pulse = 1'b1;
        repeat (65540) step();
        win_pulse = 1'b0;
        check("ovr_sat", 0, 64'(overrun_cnt[0]), 64'hFFFF);
        check("ovr_sat_seq", 0, 64'(seq_num[0]), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
